// File: rtl/serial_adder_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
//   master: issues start with operands a/b/cin, observes busy/done/sum/cout
//   slave : the adder controller itself
interface serial_adder_ctrl_if #(
  parameter int unsigned N = 4
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial N-bit adder controller: captures a/b/cin on an accepted start,
// then pushes one bit pair per clock (LSB first) through a one-bit full-adder
// cell, feeding the registered carry back in. Result appears with a one-cycle
// done pulse N edges after the accepting edge.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous reset, active-high
//   bus  - slave side of serial_adder_ctrl_if (start/a/b/cin in,
//          busy/done/sum/cout out, all outputs registered)
module serial_adder_ctrl #(
  parameter int unsigned N = 4
) (
  input  logic                clk,
  input  logic                rst,
  serial_adder_ctrl_if.slave  bus
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state;
  logic [N-1:0]   a_sr;
  logic [N-1:0]   b_sr;
  logic           c;
  logic [CW-1:0]  cnt;
  // Only the upper N-1 bits of the partial-sum shifter are ever observed;
  // bit 0 is shifted out before the result is taken.
  logic [N-2:0]   acc_hi;
  logic           busy_q;
  logic           done_q;
  logic [N-1:0]   sum_q;
  logic           cout_q;

  logic           s_c;
  logic           co_c;
  logic [N-1:0]   acc_next_c;

  // Combinational full-adder cell on the current LSB pair.
  assign s_c        = a_sr[0] ^ b_sr[0] ^ c;
  assign co_c       = (a_sr[0] & b_sr[0]) | (a_sr[0] & c) | (b_sr[0] & c);
  assign acc_next_c = {s_c, acc_hi};

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

  // Controller FSM with datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      c      <= 1'b0;
      cnt    <= '0;
      acc_hi <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sr   <= bus.a;
            b_sr   <= bus.b;
            c      <= bus.cin;
            cnt    <= '0;
            acc_hi <= '0;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          c      <= co_c;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          acc_hi <= acc_next_c[N-1:1];
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            sum_q  <= acc_next_c;
            cout_q <= co_c;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: an N=4 instance for directed adds and reset
// cases, an N=8 instance for back-to-back random adds with start held high.
// A timeline model (cycles since acceptance, pending a+b+cin) predicts every
// output each cycle; literal expectations pin the model.
module tb_serial_adder_ctrl;

  localparam int unsigned N4 = 4;
  localparam int unsigned N8 = 8;

  logic clk;
  logic rst4;
  logic rst8;

  int checks;
  int passes;
  int cyc;
  bit chk_en;

  serial_adder_ctrl_if #(.N(N4)) bus4 ();
  serial_adder_ctrl_if #(.N(N8)) bus8 ();

  serial_adder_ctrl #(.N(N4)) dut4 (.clk(clk), .rst(rst4), .bus(bus4.slave));
  serial_adder_ctrl #(.N(N8)) dut8 (.clk(clk), .rst(rst8), .bus(bus8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // phase: -1 idle, else edges since the accepting edge (done at phase==n).
  typedef struct {
    int         phase;
    logic [8:0] pend;
    logic [7:0] sum;
    logic       cout;
  } model_t;

  model_t m4;
  model_t m8;

  function automatic model_t step(input model_t m, input int n, input logic r,
                                  input logic s, input logic [7:0] a,
                                  input logic [7:0] b, input logic ci);
    model_t o;
    o = m;
    if (r) begin
      o.phase = -1;
      o.pend  = '0;
      o.sum   = '0;
      o.cout  = 1'b0;
    end else if (m.phase < 0) begin
      if (s) begin
        o.phase = 0;
        o.pend  = 9'(a) + 9'(b) + 9'(ci);
      end
    end else begin
      o.phase = m.phase + 1;
      if (o.phase == n) begin
        o.sum  = o.pend[7:0] & 8'((1 << n) - 1);
        o.cout = o.pend[n];
      end else if (o.phase > n) begin
        o.phase = -1;
      end
    end
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    else
      passes++;
  endtask

  initial begin
    m4 = '{phase: -1, pend: '0, sum: '0, cout: 1'b0};
    m8 = '{phase: -1, pend: '0, sum: '0, cout: 1'b0};
  end

  // Model advances on the same edge as the DUT; inputs only change at negedge.
  always @(posedge clk) begin
    cyc++;
    m4 = step(m4, N4, rst4, bus4.start, 8'(bus4.a), 8'(bus4.b), bus4.cin);
    m8 = step(m8, N8, rst8, bus8.start, 8'(bus8.a), 8'(bus8.b), bus8.cin);
  end

  int last_done8;
  int ndone8;

  // Per-cycle comparison against the model, plus done spacing on N=8.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy4", 32'(bus4.busy), 32'(m4.phase >= 0 && m4.phase < int'(N4)));
      check("done4", 32'(bus4.done), 32'(m4.phase == int'(N4)));
      check("sum4",  32'(bus4.sum),  32'(m4.sum));
      check("cout4", 32'(bus4.cout), 32'(m4.cout));
      check("busy8", 32'(bus8.busy), 32'(m8.phase >= 0 && m8.phase < int'(N8)));
      check("done8", 32'(bus8.done), 32'(m8.phase == int'(N8)));
      check("sum8",  32'(bus8.sum),  32'(m8.sum));
      check("cout8", 32'(bus8.cout), 32'(m8.cout));
      if (bus8.done === 1'b1) begin
        if (last_done8 >= 0) check("spacing8", 32'(cyc - last_done8), 32'(N8 + 2));
        last_done8 = cyc;
        ndone8++;
      end
    end
  end

  // Issue one add on the N=4 instance and observe a 9-cycle window.
  task automatic run_add4(input logic [3:0] a, input logic [3:0] b, input logic ci,
                          output int lat, output int busy_n, output int dones);
    int c0;
    bus4.start = 1'b1;
    bus4.a     = a;
    bus4.b     = b;
    bus4.cin   = ci;
    @(negedge clk);
    c0 = cyc;
    bus4.start = 1'b0;
    bus4.a     = 4'($urandom);
    bus4.b     = 4'($urandom);
    bus4.cin   = 1'($urandom);
    lat    = -1;
    busy_n = 0;
    dones  = 0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      if (bus4.busy === 1'b1) busy_n++;
      if (bus4.done === 1'b1) begin
        dones++;
        if (lat < 0) lat = cyc - c0;
      end
    end
  endtask

  int lat;
  int bn;
  int dn;

  initial begin
    checks     = 0;
    passes     = 0;
    cyc        = 0;
    chk_en     = 1'b0;
    last_done8 = -1;
    ndone8     = 0;
    rst4       = 1'b1;
    rst8       = 1'b1;
    bus4.start = 1'b1;
    bus4.a     = 4'($urandom);
    bus4.b     = 4'($urandom);
    bus4.cin   = 1'($urandom);
    bus8.start = 1'b1;
    bus8.a     = 8'($urandom);
    bus8.b     = 8'($urandom);
    bus8.cin   = 1'($urandom);

    // Reset held for two edges with random inputs.
    @(negedge clk);
    bus4.a = 4'($urandom);
    bus4.b = 4'($urandom);
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", 32'(bus4.busy), 32'd0);
    check("rst_done", 32'(bus4.done), 32'd0);
    check("rst_sum",  32'(bus4.sum),  32'd0);
    check("rst_cout", 32'(bus4.cout), 32'd0);
    rst4       = 1'b0;
    bus4.start = 1'b0;
    bus8.start = 1'b0;
    @(negedge clk);

    // Basic add 5+3.
    run_add4(4'h5, 4'h3, 1'b0, lat, bn, dn);
    check("basic_lat",   32'(lat), 32'd4);
    check("basic_busy",  32'(bn),  32'd4);
    check("basic_dones", 32'(dn),  32'd1);
    check("basic_sum",   32'(bus4.sum),  32'h8);
    check("basic_cout",  32'(bus4.cout), 32'd0);

    // Carry chain.
    run_add4(4'hF, 4'h1, 1'b0, lat, bn, dn);
    check("chain1_sum",  32'(bus4.sum),  32'h0);
    check("chain1_cout", 32'(bus4.cout), 32'd1);
    run_add4(4'hF, 4'hF, 1'b1, lat, bn, dn);
    check("chain2_sum",  32'(bus4.sum),  32'hF);
    check("chain2_cout", 32'(bus4.cout), 32'd1);

    // Start pulsed during SHIFT must be ignored.
    bus4.start = 1'b1;
    bus4.a     = 4'h6;
    bus4.b     = 4'h9;
    bus4.cin   = 1'b0;
    @(negedge clk);
    bus4.start = 1'b0;
    @(negedge clk);
    bus4.start = 1'b1;
    bus4.a     = 4'h1;
    bus4.b     = 4'h1;
    @(negedge clk);
    bus4.start = 1'b0;
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus4.done === 1'b1) dn++;
      @(negedge clk);
    end
    check("ign_dones", 32'(dn), 32'd1);
    check("ign_sum",   32'(bus4.sum),  32'hF);
    check("ign_cout",  32'(bus4.cout), 32'd0);
    run_add4(4'h1, 4'h1, 1'b0, lat, bn, dn);
    check("after_ign_sum", 32'(bus4.sum), 32'h2);

    // Reset on the second SHIFT cycle discards the add.
    bus4.start = 1'b1;
    bus4.a     = 4'h3;
    bus4.b     = 4'h4;
    @(negedge clk);
    bus4.start = 1'b0;
    @(negedge clk);
    rst4 = 1'b1;
    @(negedge clk);
    rst4 = 1'b0;
    check("mid_rst_busy", 32'(bus4.busy), 32'd0);
    check("mid_rst_sum",  32'(bus4.sum),  32'd0);
    check("mid_rst_cout", 32'(bus4.cout), 32'd0);
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus4.done === 1'b1) dn++;
      @(negedge clk);
    end
    check("mid_rst_dones", 32'(dn), 32'd0);
    run_add4(4'h7, 4'h9, 1'b1, lat, bn, dn);
    check("post_rst_sum",  32'(bus4.sum),  32'h1);
    check("post_rst_cout", 32'(bus4.cout), 32'd1);

    // N=8: 1000 back-to-back random adds with start held high.
    rst8       = 1'b0;
    bus8.start = 1'b1;
    for (int i = 0; i < 1000 * (N8 + 2) + 50 && ndone8 < 1000; i++) begin
      bus8.a   = 8'($urandom);
      bus8.b   = 8'($urandom);
      bus8.cin = 1'($urandom);
      @(negedge clk);
    end
    bus8.start = 1'b0;
    check("n8_done_count", 32'(ndone8), 32'd1000);
    repeat (N8 + 3) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
